// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared buffer state type and depth for fifo_reader
package fifo_pkg;

  localparam int FIFO_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Number of words held in a given buffer state
  function automatic logic [1:0] buf_words(input buf_state_e s);
    case (s)
      ONE:     buf_words = 2'd1;
      TWO:     buf_words = 2'd2;
      default: buf_words = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// rtl/fifo_reader_skid.sv - two-entry output buffer with load, pop and flush
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              pop_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic [1:0]        count_o
);

  buf_state_e        state_q, state_d;
  logic [DWIDTH-1:0] head_q, head_d;
  logic [DWIDTH-1:0] tail_q, tail_d;

  // Buffer state register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy: +1 on load only, -1 on pop only, flush empties the buffer
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (load_i && !pop_i) begin
      case (state_q)
        EMPTY:   state_d = ONE;
        ONE:     state_d = TWO;
        default: state_d = state_q;
      endcase
    end else if (pop_i && !load_i) begin
      case (state_q)
        ONE:     state_d = EMPTY;
        TWO:     state_d = ONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Entry contents: a word loaded while the head leaves becomes the new head
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (!flush_i) begin
      case (state_q)
        EMPTY: begin
          if (load_i) head_d = data_i;
        end
        ONE: begin
          if (load_i) begin
            if (pop_i) head_d = data_i;
            else       tail_d = data_i;
          end
        end
        TWO: begin
          if (pop_i) begin
            head_d = tail_q;
            if (load_i) tail_d = data_i;
          end
        end
        default: begin
          head_d = head_q;
        end
      endcase
    end
  end

  // Entry registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Stream outputs come straight from the head register
  always_comb begin
    valid_o = (state_q != EMPTY);
    data_o  = head_q;
    count_o = buf_words(state_q);
  end

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO to valid/ready stream adapter; optional FIFO_READER_STATS_EN statistics
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 4,
  parameter int SHOWAHEAD = 1
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  input  logic              flush_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]       words_o,
  output logic [AWIDTH:0]   min_level_o
`endif
);

  logic       run_q;
  logic       inflight_q, inflight_d;
  logic       pop;
  logic       load;
  logic [1:0] buf_cnt;
  logic [2:0] occupancy;

  // Requests are held off until the first edge after reset release
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Pop, request and load decisions; a word already requested counts as occupancy
  always_comb begin
    pop          = valid_o && ready_i && !flush_i;
    occupancy    = {1'b0, buf_cnt} + {2'b00, inflight_q};
    fifo_rdreq_o = run_q && !fifo_empty_i && !flush_i &&
                   (occupancy < (3'(FIFO_BUF_DEPTH) + {2'b00, pop}));
    if (SHOWAHEAD != 0) begin
      load       = fifo_rdreq_o;
      inflight_d = 1'b0;
    end else begin
      load       = inflight_q && !flush_i;
      inflight_d = fifo_rdreq_o;
    end
  end

  // In-flight marker for non-showahead reads
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_reader_skid #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush_i (flush_i),
    .load_i  (load),
    .pop_i   (pop),
    .data_i  (fifo_q_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .count_o (buf_cnt)
  );

`ifdef FIFO_READER_STATS_EN
  logic [31:0]     words_q, words_d;
  logic [AWIDTH:0] min_level_q, min_level_d;

  // Transfer count wraps; minimum level tracks usedw on request cycles
  always_comb begin
    words_d     = pop ? words_q + 32'd1 : words_q;
    min_level_d = (fifo_rdreq_o && (fifo_usedw_i < min_level_q)) ? fifo_usedw_i : min_level_q;
  end

  // Statistics registers survive flush, cleared only by reset
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      words_q     <= '0;
      min_level_q <= '1;
    end else begin
      words_q     <= words_d;
      min_level_q <= min_level_d;
    end
  end

  assign words_o     = words_q;
  assign min_level_o = min_level_q;
`else
  logic unused_usedw;
  assign unused_usedw = ^fifo_usedw_i;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - self-checking bench for fifo_reader in both read modes
module tb_fifo_reader;

  logic            clk = 1'b0;
  logic            arstn;
  logic [1:0]      fe, frd, fl, vout, rdy;
  logic [1:0][31:0] fq, dout;
  logic [1:0][4:0] fu;
`ifdef FIFO_READER_STATS_EN
  logic [1:0][31:0] wo;
  logic [1:0][4:0]  ml;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // environment and reference model, index 0 = showahead, 1 = registered read
  logic [31:0] fifo_m [2][$];
  logic [31:0] held   [2][$];
  logic [31:0] qreg   [2];
  bit          pending[2];
  bit          run    [2];
  int unsigned words  [2];
  logic [4:0]  minlvl [2];

  logic [31:0] got  [2][$];
  int          gotc [2][$];
  int          rdcnt[2];
  bit          cmp_en = 1'b0;

  initial forever #5 clk = ~clk;

  fifo_reader #(.DWIDTH(32), .AWIDTH(4), .SHOWAHEAD(1)) u_sa (
    .clk_i(clk), .arstn_i(arstn), .fifo_q_i(fq[0]), .fifo_empty_i(fe[0]),
    .fifo_usedw_i(fu[0]), .fifo_rdreq_o(frd[0]), .flush_i(fl[0]),
    .data_o(dout[0]), .valid_o(vout[0]), .ready_i(rdy[0])
`ifdef FIFO_READER_STATS_EN
    , .words_o(wo[0]), .min_level_o(ml[0])
`endif
  );

  fifo_reader #(.DWIDTH(32), .AWIDTH(4), .SHOWAHEAD(0)) u_nsa (
    .clk_i(clk), .arstn_i(arstn), .fifo_q_i(fq[1]), .fifo_empty_i(fe[1]),
    .fifo_usedw_i(fu[1]), .fifo_rdreq_o(frd[1]), .flush_i(fl[1]),
    .data_o(dout[1]), .valid_o(vout[1]), .ready_i(rdy[1])
`ifdef FIFO_READER_STATS_EN
    , .words_o(wo[1]), .min_level_o(ml[1])
`endif
  );

  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] w);
    total++;
    if (g !== w) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, g, w, $time);
    end
  endtask

  // a read is issued when words held plus words on the way, minus the one leaving, leave room
  function automatic bit exp_rd(input int m);
    int occ;
    bit p;
    p   = (held[m].size() > 0) && rdy[m] && !fl[m];
    occ = held[m].size() + int'(pending[m]) - int'(p);
    return arstn && run[m] && (fifo_m[m].size() > 0) && !fl[m] && (occ < 2);
  endfunction

  task automatic model_reset(input int m);
    held[m].delete();
    pending[m] = 1'b0;
    run[m]     = 1'b0;
    words[m]   = 0;
    minlvl[m]  = 5'h1f;
  endtask

  // advance the model over the clock edge that just passed
  task automatic step();
    for (int m = 0; m < 2; m++) begin
      bit rd, p;
      int lvl;
      if (!arstn) begin
        model_reset(m);
      end else begin
        rd  = exp_rd(m);
        p   = (held[m].size() > 0) && rdy[m] && !fl[m];
        lvl = fifo_m[m].size();
        if (fl[m]) begin
          held[m].delete();
          pending[m] = 1'b0;
        end else begin
          if (p) begin
            void'(held[m].pop_front());
            words[m]++;
          end
          if (rd && (lvl < int'(minlvl[m]))) minlvl[m] = 5'(lvl);
          if (m == 0) begin
            if (rd) held[m].push_back(fifo_m[m].pop_front());
          end else begin
            if (pending[m]) held[m].push_back(qreg[m]);
            if (rd) qreg[m] = fifo_m[m].pop_front();
            pending[m] = rd;
          end
        end
        run[m] = 1'b1;
      end
    end
  endtask

  task automatic drive();
    for (int m = 0; m < 2; m++) begin
      fe[m] = (fifo_m[m].size() == 0);
      fu[m] = 5'(fifo_m[m].size());
      if (m == 0) fq[m] = (fifo_m[m].size() > 0) ? fifo_m[m][0] : 32'h0;
      else        fq[m] = qreg[m];
    end
  endtask

  task automatic push(input int m, input logic [31:0] v);
    if (fifo_m[m].size() < 16) fifo_m[m].push_back(v);
  endtask

  task automatic clear_log();
    for (int m = 0; m < 2; m++) begin
      got[m].delete();
      gotc[m].delete();
      rdcnt[m] = 0;
    end
  endtask

  // apply inputs, record what the DUT transfers at the coming edge, cross the edge
  task automatic go();
    drive();
    #1;
    for (int m = 0; m < 2; m++) begin
      if (vout[m] && rdy[m] && !fl[m]) begin
        got[m].push_back(dout[m]);
        gotc[m].push_back(cyc);
      end
      if (frd[m]) rdcnt[m]++;
    end
    @(posedge clk);
    #1;
    step();
    cyc++;
  endtask

  // every cycle: DUT outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("valid%0d", m), vout[m], held[m].size() > 0);
        if (held[m].size() > 0) chk($sformatf("data%0d", m), dout[m], held[m][0]);
        chk($sformatf("rdreq%0d", m), frd[m], exp_rd(m));
      end
    end
  end

  initial begin
    int k;
    arstn = 1'b0;
    rdy   = '0;
    fl    = '0;
    for (int m = 0; m < 2; m++) begin
      qreg[m] = '0;
      model_reset(m);
    end
    drive();
    cmp_en = 1'b1;
    go();
    go();
    drive();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_valid%0d", m), vout[m], 0);
      chk($sformatf("rst_rdreq%0d", m), frd[m], 0);
      chk($sformatf("rst_data%0d", m), dout[m], 0);
`ifdef FIFO_READER_STATS_EN
      chk($sformatf("rst_words%0d", m), wo[m], 0);
      chk($sformatf("rst_minlvl%0d", m), ml[m], 5'h1f);
`endif
    end
    #1 arstn = 1'b1;
    go(); go(); go();

    // preload 1..8 with ready held high
    clear_log();
    rdy = 2'b11;
    for (int m = 0; m < 2; m++) for (int i = 1; i <= 8; i++) push(m, 32'(i));
    k = cyc;
    for (int i = 0; i < 12; i++) go();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("t1_count%0d", m), got[m].size(), 8);
      chk($sformatf("t1_rdreqs%0d", m), rdcnt[m], 8);
      for (int i = 0; i < 8; i++) begin
        if (i < got[m].size()) begin
          chk($sformatf("t1_word%0d_%0d", m, i), got[m][i], i + 1);
          chk($sformatf("t1_cycle%0d_%0d", m, i), gotc[m][i], k + 1 + m + i);
        end
      end
`ifdef FIFO_READER_STATS_EN
      chk($sformatf("t1_words_o%0d", m), wo[m], 8);
      chk($sformatf("t1_minlvl%0d", m), ml[m], 1);
`endif
    end

    // back-pressure: 0xA,0xB,0xC with ready low for five cycles
    clear_log();
    rdy = 2'b00;
    for (int m = 0; m < 2; m++) begin
      push(m, 32'hA); push(m, 32'hB); push(m, 32'hC);
    end
    for (int i = 0; i < 5; i++) go();
    drive();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("t2_valid%0d", m), vout[m], 1);
      chk($sformatf("t2_head%0d", m), dout[m], 32'hA);
      chk($sformatf("t2_rdreq%0d", m), frd[m], 0);
      chk($sformatf("t2_reads%0d", m), rdcnt[m], 2);
    end
    clear_log();
    rdy = 2'b11;
    for (int i = 0; i < 6; i++) go();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("t2_count%0d", m), got[m].size(), 3);
      for (int i = 0; i < 3; i++)
        if (i < got[m].size()) chk($sformatf("t2_word%0d_%0d", m, i), got[m][i], 32'hA + i);
    end

    // flush while 0x55 is on its way
    clear_log();
    for (int m = 0; m < 2; m++) begin
      push(m, 32'h55); push(m, 32'h66);
    end
    go();
    fl = 2'b11;
    go();
    fl = 2'b00;
    drive();
    #1;
    for (int m = 0; m < 2; m++) chk($sformatf("t3_valid%0d", m), vout[m], 0);
    for (int i = 0; i < 5; i++) go();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("t3_count%0d", m), got[m].size(), 1);
      if (got[m].size() > 0) chk($sformatf("t3_word%0d", m), got[m][0], 32'h66);
    end

    // asynchronous reset in the middle of a stream
    for (int m = 0; m < 2; m++) for (int i = 0; i < 6; i++) push(m, 32'h100 + i);
    go(); go(); go();
    #2;
    arstn = 1'b0;
    for (int m = 0; m < 2; m++) model_reset(m);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("t4_valid%0d", m), vout[m], 0);
      chk($sformatf("t4_rdreq%0d", m), frd[m], 0);
      chk($sformatf("t4_data%0d", m), dout[m], 0);
    end
    go();
    #2;
    arstn = 1'b1;
    clear_log();
    #1;
    for (int m = 0; m < 2; m++) chk($sformatf("t4_early_rdreq%0d", m), frd[m], 0);
    for (int i = 0; i < 8; i++) go();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("t4_count%0d", m), got[m].size(), 3);
      for (int i = 0; i < 3; i++)
        if (i < got[m].size()) chk($sformatf("t4_word%0d_%0d", m, i), got[m][i], 32'h103 + i);
    end

    // random traffic, flushes and back-pressure
    for (int blk = 0; blk < 15; blk++) begin
      int pp, rp;
      pp = $urandom_range(1, 9);
      rp = $urandom_range(2, 10);
      for (int i = 0; i < 200; i++) begin
        for (int m = 0; m < 2; m++) begin
          rdy[m] = ($urandom_range(0, 9) < rp);
          fl[m]  = ($urandom_range(0, 59) == 0);
          if ($urandom_range(0, 9) < pp) push(m, $urandom);
          if ($urandom_range(0, 9) < pp) push(m, $urandom);
        end
        go();
      end
    end

    // drain
    rdy = 2'b11;
    fl  = 2'b00;
    for (int i = 0; i < 40; i++) go();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("end_valid%0d", m), vout[m], 0);
      chk($sformatf("end_empty%0d", m), fe[m], 1);
`ifdef FIFO_READER_STATS_EN
      chk($sformatf("end_words%0d", m), wo[m], words[m]);
      chk($sformatf("end_minlvl%0d", m), ml[m], minlvl[m]);
`endif
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
